// File: rtl/shift_pkg.sv
// Shared op codes and elaboration-time helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Earlier stages absorb the remainder so the deepest logic sits near the input.
  function automatic int stage_levels(input int levels, input int stages, input int k);
    return (levels / stages) + ((k < (levels % stages)) ? 1 : 0);
  endfunction

  function automatic int stage_first(input int levels, input int stages, input int k);
    int first;
    first = 0;
    for (int j = 0; j < k; j++) begin
      first += stage_levels(levels, stages, j);
    end
    return first;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: a run of consecutive barrel levels followed by the stage register.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      advance,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [2:0]                in_op,
  input  logic [clog2(WIDTH)-1:0]   in_amt,
  input  logic                      in_carry,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [2:0]                out_op,
  output logic [clog2(WIDTH)-1:0]   out_amt,
  output logic                      out_carry
);

  localparam int AW = clog2(WIDTH);

  logic [WIDTH-1:0] lvl_data  [0:NUM_LEVELS];
  logic             lvl_carry [0:NUM_LEVELS];

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic [2:0]       op_reg;
  logic [AW-1:0]    amt_reg;
  logic             carry_reg;

  assign lvl_data[0]  = in_data;
  assign lvl_carry[0] = in_carry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
      localparam int SH = 2 ** (FIRST_LEVEL + gi);
      logic [WIDTH-1:0] shifted;
      logic             carry_out;

      // The carry tracks the bit leaving on the last level that actually shifts,
      // which is the overall last bit shifted out.
      always_comb begin
        shifted   = lvl_data[gi];
        carry_out = lvl_carry[gi];
        if (in_amt[FIRST_LEVEL + gi]) begin
          case (in_op)
            OP_SRL: begin
              shifted   = lvl_data[gi] >> SH;
              carry_out = lvl_data[gi][SH-1];
            end
            OP_SRA: begin
              shifted   = $signed(lvl_data[gi]) >>> SH;
              carry_out = lvl_data[gi][SH-1];
            end
            OP_SLL: begin
              shifted   = lvl_data[gi] << SH;
              carry_out = lvl_data[gi][WIDTH-SH];
            end
            OP_ROR: begin
              shifted   = (lvl_data[gi] >> SH) | (lvl_data[gi] << (WIDTH - SH));
              carry_out = shifted[WIDTH-1];
            end
            OP_ROL: begin
              shifted   = (lvl_data[gi] << SH) | (lvl_data[gi] >> (WIDTH - SH));
              carry_out = shifted[0];
            end
            default: begin
              shifted   = lvl_data[gi];
              carry_out = lvl_carry[gi];
            end
          endcase
        end
      end

      assign lvl_data[gi+1]  = shifted;
      assign lvl_carry[gi+1] = carry_out;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      op_reg    <= '0;
      amt_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (advance) begin
      valid_reg <= in_valid;
      data_reg  <= lvl_data[NUM_LEVELS];
      op_reg    <= in_op;
      amt_reg   <= in_amt;
      carry_reg <= lvl_carry[NUM_LEVELS];
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_op    = op_reg;
  assign out_amt   = amt_reg;
  assign out_carry = carry_reg;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with a single global advance and valid/ready on both sides.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [2:0]              in_op,
  input  logic [clog2(WIDTH)-1:0] in_amt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_carry,
  output logic                    out_zero,
  output logic                    out_err
);

  localparam int LEVELS = clog2(WIDTH);

  logic             advance;
  logic             valid_chain [0:STAGES];
  logic [WIDTH-1:0] data_chain  [0:STAGES];
  logic [2:0]       op_chain    [0:STAGES];
  logic [LEVELS-1:0] amt_chain  [0:STAGES];
  logic             carry_chain [0:STAGES];

  // No skid buffer: the whole pipe moves together, bubbles included.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  assign valid_chain[0] = in_valid & advance;
  assign data_chain[0]  = in_data;
  assign op_chain[0]    = in_op;
  assign amt_chain[0]   = in_amt;
  assign carry_chain[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      shift_stage #(
        .WIDTH       (WIDTH),
        .FIRST_LEVEL (stage_first(LEVELS, STAGES, gi)),
        .NUM_LEVELS  (stage_levels(LEVELS, STAGES, gi))
      ) u_stage (
        .clock     (clock),
        .reset_n   (reset_n),
        .advance   (advance),
        .in_valid  (valid_chain[gi]),
        .in_data   (data_chain[gi]),
        .in_op     (op_chain[gi]),
        .in_amt    (amt_chain[gi]),
        .in_carry  (carry_chain[gi]),
        .out_valid (valid_chain[gi+1]),
        .out_data  (data_chain[gi+1]),
        .out_op    (op_chain[gi+1]),
        .out_amt   (amt_chain[gi+1]),
        .out_carry (carry_chain[gi+1])
      );
    end
  endgenerate

  assign out_valid = valid_chain[STAGES];
  assign out_data  = data_chain[STAGES];
  assign out_carry = carry_chain[STAGES];
  assign out_zero  = (data_chain[STAGES] == '0);
  // Illegal codes pass through every level untouched; flag them at the output.
  assign out_err   = (op_chain[STAGES] > OP_ROL);

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit/2-stage main instance plus 8- and 64-bit sweep instances.
module tb_shift_pipe;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Main instance: WIDTH=32, STAGES=2
  logic        in_valid, in_ready, out_valid, out_ready, out_carry, out_zero, out_err;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_op;
  logic [4:0]  in_amt;

  shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .out_zero(out_zero), .out_err(out_err)
  );

  // Sweep instances, always ready downstream
  logic       sw_ready;
  logic       s8_valid;
  logic [7:0] s8_data;
  logic [2:0] s8_op;
  logic [2:0] s8_amt;
  logic       a8_rdy, a8_valid, a8_carry, a8_zero, a8_err;
  logic       b8_rdy, b8_valid, b8_carry, b8_zero, b8_err;
  logic [7:0] a8_data, b8_data;

  logic        s64_valid;
  logic [63:0] s64_data;
  logic [2:0]  s64_op;
  logic [5:0]  s64_amt;
  logic        a64_rdy, a64_valid, a64_carry, a64_zero, a64_err;
  logic        b64_rdy, b64_valid, b64_carry, b64_zero, b64_err;
  logic [63:0] a64_data, b64_data;

  shift_pipe #(.WIDTH(8), .STAGES(1)) u8a (
    .clock(clock), .reset_n(reset_n), .in_valid(s8_valid), .in_ready(a8_rdy),
    .in_data(s8_data), .in_op(s8_op), .in_amt(s8_amt), .out_valid(a8_valid),
    .out_ready(sw_ready), .out_data(a8_data), .out_carry(a8_carry),
    .out_zero(a8_zero), .out_err(a8_err)
  );
  shift_pipe #(.WIDTH(8), .STAGES(3)) u8b (
    .clock(clock), .reset_n(reset_n), .in_valid(s8_valid), .in_ready(b8_rdy),
    .in_data(s8_data), .in_op(s8_op), .in_amt(s8_amt), .out_valid(b8_valid),
    .out_ready(sw_ready), .out_data(b8_data), .out_carry(b8_carry),
    .out_zero(b8_zero), .out_err(b8_err)
  );
  shift_pipe #(.WIDTH(64), .STAGES(1)) u64a (
    .clock(clock), .reset_n(reset_n), .in_valid(s64_valid), .in_ready(a64_rdy),
    .in_data(s64_data), .in_op(s64_op), .in_amt(s64_amt), .out_valid(a64_valid),
    .out_ready(sw_ready), .out_data(a64_data), .out_carry(a64_carry),
    .out_zero(a64_zero), .out_err(a64_err)
  );
  shift_pipe #(.WIDTH(64), .STAGES(6)) u64b (
    .clock(clock), .reset_n(reset_n), .in_valid(s64_valid), .in_ready(b64_rdy),
    .in_data(s64_data), .in_op(s64_op), .in_amt(s64_amt), .out_valid(b64_valid),
    .out_ready(sw_ready), .out_data(b64_data), .out_carry(b64_carry),
    .out_zero(b64_zero), .out_err(b64_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: returns {err, carry, data[63:0]}.
  function automatic logic [65:0] model(input logic [63:0] d, input logic [2:0] op,
                                        input int amt, input int w);
    logic [63:0] mask, r, s;
    logic        c;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    r = d;
    c = 1'b0;
    if (op > 3'd4) return {1'b1, 1'b0, d};
    if (amt == 0) return {1'b0, 1'b0, d};
    case (op)
      3'd0: begin r = d >> amt; c = d[amt-1]; end
      3'd1: begin
        s = d | (d[w-1] ? ~mask : 64'd0);
        r = 64'($signed(s) >>> amt) & mask;
        c = d[amt-1];
      end
      3'd2: begin r = (d << amt) & mask; c = d[w-amt]; end
      3'd3: begin r = ((d >> amt) | (d << (w - amt))) & mask; c = r[w-1]; end
      default: begin r = ((d << amt) | (d >> (w - amt))) & mask; c = r[0]; end
    endcase
    return {1'b0, c, r};
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] amt, input logic [31:0] exp_d,
                        input logic exp_c, input logic exp_e);
    int cycles;
    @(negedge clock);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = amt;
    #1;
    check({tag, " in_ready"}, in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 10) begin
      @(negedge clock);
      cycles++;
    end
    // out_valid rises on the second edge counting the accepting edge.
    check({tag, " latency"}, cycles, 1);
    check({tag, " valid"}, out_valid, 1'b1);
    check({tag, " data"}, out_data, exp_d);
    check({tag, " carry"}, out_carry, exp_c);
    check({tag, " zero"}, out_zero, (exp_d == 32'd0));
    check({tag, " err"}, out_err, exp_e);
    $display("txn %s: op=%0d in=%08h amt=%0d -> out=%08h c=%0b z=%0b e=%0b",
             tag, op, d, amt, out_data, out_carry, out_zero, out_err);
  endtask

  logic [2:0]  bp_op   [5];
  logic [31:0] bp_in   [5];
  logic [4:0]  bp_amt  [5];
  logic [32:0] bp_exp  [5];
  logic        bp_rdy  [10];

  initial begin
    int sent, got;
    logic [65:0] m;
    logic [7:0]  d8;
    logic [63:0] d64;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_amt    = '0;
    out_ready = 1'b1;
    sw_ready  = 1'b1;
    s8_valid  = 1'b0; s8_data  = '0; s8_op  = '0; s8_amt  = '0;
    s64_valid = 1'b0; s64_data = '0; s64_op = '0; s64_amt = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst valid", out_valid, 1'b0);
    check("rst data",  out_data, 32'd0);
    check("rst zero",  out_zero, 1'b1);
    check("rst carry", out_carry, 1'b0);
    check("rst err",   out_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst in_ready", in_ready, 1'b1);

    // Directed single operations
    run_op("sra",      3'b001, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
    run_op("srl",      3'b000, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b1, 1'b0);
    run_op("sll31",    3'b010, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    run_op("sll_out",  3'b010, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 1'b0);
    run_op("ror",      3'b011, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0);
    run_op("rol",      3'b100, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 1'b0);
    run_op("srl0",     3'b000, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    run_op("sra0",     3'b001, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    run_op("sll0",     3'b010, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    run_op("ror0",     3'b011, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    run_op("rol0",     3'b100, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b0);
    run_op("illegal",  3'b111, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0, 1'b1);

    // Back-to-back with downstream stalled on cycles 3..5
    bp_op[0] = 3'b000; bp_in[0] = 32'h0000_00F0; bp_amt[0] = 5'd4;  bp_exp[0] = {32'h0000_000F, 1'b0};
    bp_op[1] = 3'b010; bp_in[1] = 32'h0100_0001; bp_amt[1] = 5'd8;  bp_exp[1] = {32'h0000_0100, 1'b1};
    bp_op[2] = 3'b011; bp_in[2] = 32'h0000_000F; bp_amt[2] = 5'd4;  bp_exp[2] = {32'hF000_0000, 1'b1};
    bp_op[3] = 3'b001; bp_in[3] = 32'h8000_0010; bp_amt[3] = 5'd4;  bp_exp[3] = {32'hF800_0001, 1'b0};
    bp_op[4] = 3'b100; bp_in[4] = 32'h0000_0001; bp_amt[4] = 5'd31; bp_exp[4] = {32'h8000_0000, 1'b0};
    bp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clock);
    sent = 0;
    got  = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 5) begin
        in_valid = 1'b1;
        in_op    = bp_op[sent];
        in_data  = bp_in[sent];
        in_amt   = bp_amt[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c <= 10) check($sformatf("bp in_ready c%0d", c), in_ready, bp_rdy[c-1]);
      if (c >= 3 && c <= 5)
        check($sformatf("bp stall hold c%0d", c), {out_valid, out_data, out_carry, out_zero, out_err},
              {1'b1, bp_exp[0], 1'b0, 1'b0});
      if (out_valid && out_ready) begin
        if (got < 5) begin
          check($sformatf("bp result %0d", got), {out_data, out_carry}, bp_exp[got]);
          $display("txn bp %0d: out=%08h c=%0b", got, out_data, out_carry);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp result count", got, 5);

    // Reset with two operations in flight
    @(negedge clock);
    in_valid = 1'b1; in_op = 3'b000; in_data = 32'h0000_0100; in_amt = 5'd4;
    @(negedge clock);
    in_op = 3'b010; in_data = 32'h0000_0001; in_amt = 5'd3;
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid rst valid", out_valid, 1'b0);
    check("mid rst data",  out_data, 32'd0);
    check("mid rst zero",  out_zero, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("post rst quiet %0d", k), out_valid, 1'b0);
    end
    $display("txn reset: in-flight operations discarded");
    run_op("after_rst", 3'b000, 32'h0000_0100, 5'd4, 32'h0000_0010, 1'b0, 1'b0);

    // WIDTH=8 sweep, STAGES=1 and 3
    d8 = 8'h96;
    for (int di = 0; di < 3; di++) begin
      for (int op = 0; op < 8; op++) begin
        for (int a = 0; a < 8; a++) begin
          @(negedge clock);
          s8_valid = 1'b1; s8_data = d8; s8_op = 3'(op); s8_amt = 3'(a);
          m = model({56'd0, d8}, 3'(op), a, 8);
          @(negedge clock);
          s8_valid = 1'b0;
          check($sformatf("w8s1 op%0d amt%0d d%02h", op, a, d8),
                {a8_valid, a8_data, a8_carry, a8_zero, a8_err},
                {1'b1, m[7:0], m[64], (m[7:0] == 8'd0), m[65]});
          repeat (2) @(negedge clock);
          check($sformatf("w8s3 op%0d amt%0d d%02h", op, a, d8),
                {b8_valid, b8_data, b8_carry, b8_zero, b8_err},
                {1'b1, m[7:0], m[64], (m[7:0] == 8'd0), m[65]});
        end
      end
      d8 = d8 + 8'h35;
    end

    // WIDTH=64 sweep, STAGES=1 and 6
    d64 = 64'h8000_0000_0000_0001;
    for (int di = 0; di < 3; di++) begin
      for (int op = 0; op < 8; op++) begin
        for (int a = 0; a < 64; a++) begin
          @(negedge clock);
          s64_valid = 1'b1; s64_data = d64; s64_op = 3'(op); s64_amt = 6'(a);
          m = model(d64, 3'(op), a, 64);
          @(negedge clock);
          s64_valid = 1'b0;
          check($sformatf("w64s1 op%0d amt%0d d%016h", op, a, d64),
                {a64_valid, a64_data, a64_carry, a64_zero, a64_err},
                {1'b1, m[63:0], m[64], (m[63:0] == 64'd0), m[65]});
          repeat (5) @(negedge clock);
          check($sformatf("w64s6 op%0d amt%0d d%016h", op, a, d64),
                {b64_valid, b64_data, b64_carry, b64_zero, b64_err},
                {1'b1, m[63:0], m[64], (m[63:0] == 64'd0), m[65]});
        end
      end
      d64 = d64 + 64'h1357_9BDF_2468_ACE1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
